// File: rtl/fifo_rd_stream_a16d32_pkg.sv
// Shared constants and occupancy encoding for the a16d32 FIFO read-side stream.
package fifo_pkg;

  localparam int DEF_PTR_WIDTH = 4;
  localparam int DEF_DAT_WIDTH = 32;
  localparam int DEF_CNT_WIDTH = 16;
  localparam int SKID_DEPTH    = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_rd_stream_a16d32_if.sv
// FIFO read-port and output-stream bundle; master is the drain engine, slave the environment.
interface fifo_rd_stream_a16d32_if
  import fifo_pkg::*;
#(
  parameter int DAT_WIDTH = DEF_DAT_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
  logic                 fifo_empty;
  logic [DAT_WIDTH-1:0] fifo_rd_data;
  logic                 fifo_rd_empty_err;
  logic                 fifo_rd_op;
  logic                 out_valid;
  logic                 out_ready;
  logic [DAT_WIDTH-1:0] out_data;
  logic [1:0]           out_level;
  logic [CNT_WIDTH-1:0] rd_cnt;
  logic                 err_sticky;

  modport master (
    input  fifo_empty, fifo_rd_data, fifo_rd_empty_err, out_ready,
    output fifo_rd_op, out_valid, out_data, out_level, rd_cnt, err_sticky
  );

  modport slave (
    output fifo_empty, fifo_rd_data, fifo_rd_empty_err, out_ready,
    input  fifo_rd_op, out_valid, out_data, out_level, rd_cnt, err_sticky
  );
endinterface

// File: rtl/fifo_rd_stream_a16d32_skid2.sv
// Two-entry head/tail skid buffer absorbing the RF read latency; head is the visible word.
module fifo_rd_skid2
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DAT_WIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output occ_e              o_occ,
  output logic              o_ovf
);
  occ_e              r_occ, w_occ_nxt;
  logic [DATA_W-1:0] r_head, r_tail;
  logic              w_ld_head_in, w_ld_head_tail, w_ld_tail, w_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_occ <= OCC_EMPTY;
    else          r_occ <= w_occ_nxt;
  end

  always_comb begin
    w_occ_nxt      = r_occ;
    w_ld_head_in   = 1'b0;
    w_ld_head_tail = 1'b0;
    w_ld_tail      = 1'b0;
    w_ovf          = 1'b0;
    if (i_clear) begin
      w_occ_nxt = OCC_EMPTY;
    end else begin
      case (r_occ)
        OCC_EMPTY: if (i_push) begin
          w_ld_head_in = 1'b1;
          w_occ_nxt    = OCC_ONE;
        end
        OCC_ONE: begin
          if (i_push && i_pop) w_ld_head_in = 1'b1;
          else if (i_push) begin
            w_ld_tail = 1'b1;
            w_occ_nxt = OCC_TWO;
          end else if (i_pop) w_occ_nxt = OCC_EMPTY;
        end
        OCC_TWO: begin
          if (i_pop) begin
            w_ld_head_tail = 1'b1;
            if (i_push) w_ld_tail = 1'b1;
            else        w_occ_nxt = OCC_ONE;
          end else if (i_push) begin
            // Full with no drain: the returning word has nowhere to go.
            w_ovf = 1'b1;
          end
        end
        default: w_occ_nxt = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_ld_head_in)        r_head <= i_push_data;
      else if (w_ld_head_tail) r_head <= r_tail;
      if (w_ld_tail)           r_tail <= i_push_data;
    end
  end

  assign o_head = r_head;
  assign o_occ  = r_occ;
  assign o_ovf  = w_ovf;
endmodule

// File: rtl/fifo_rd_stream_a16d32.sv
// FIFO drain engine: issues reads, tracks the in-flight RF return, presents a valid/ready stream.
module fifo_rd_stream_a16d32
  import fifo_pkg::*;
#(
  parameter int DAT_WIDTH = DEF_DAT_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sreset_n,
  fifo_rd_stream_a16d32_if.master        bus
);
  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_rd_cnt;
  logic                 r_err;
  occ_e                 w_occ;
  logic [DAT_WIDTH-1:0] w_head;
  logic                 w_valid, w_pop, w_ovf, w_rd_op;
  logic [2:0]           w_occ_after;

  assign w_valid     = (w_occ != OCC_EMPTY);
  assign w_pop       = w_valid & bus.out_ready;
  assign w_occ_after = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  // Issue only if the word would still fit once the in-flight return lands.
  assign w_rd_op     = reset_n & sreset_n & ~bus.fifo_empty & (w_occ_after < 3'(SKID_DEPTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= 1'b0;
      r_rd_cnt   <= '0;
      r_err      <= 1'b0;
    end else if (!sreset_n) begin
      r_inflight <= 1'b0;
      r_rd_cnt   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= w_rd_op;
      if (w_pop)                             r_rd_cnt <= r_rd_cnt + 1'b1;
      if (bus.fifo_rd_empty_err || w_ovf)    r_err    <= 1'b1;
    end
  end

  fifo_rd_skid2 #(.DATA_W(DAT_WIDTH)) u_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clear     (~sreset_n),
    .i_push      (r_inflight),
    .i_push_data (bus.fifo_rd_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_occ       (w_occ),
    .o_ovf       (w_ovf)
  );

  assign bus.fifo_rd_op = w_rd_op;
  assign bus.out_valid  = w_valid;
  assign bus.out_data   = w_head;
  assign bus.out_level  = w_occ;
  assign bus.rd_cnt     = r_rd_cnt;
  assign bus.err_sticky = r_err;
endmodule

// File: tb/tb_fifo_rd_stream_a16d32.sv
// Randomized scoreboard bench: a queue-based FIFO model feeds the DUT; a monitor checks delivered order.
module tb_fifo_rd_stream_a16d32;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sreset_n = 1'b1;

  fifo_rd_stream_a16d32_if #(.DAT_WIDTH(32), .CNT_WIDTH(16)) bus();

  fifo_rd_stream_a16d32 #(.DAT_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sreset_n (sreset_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_read   = 0;
  int          n_deliv  = 0;
  int          n_lost   = 0;
  logic [15:0] model_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Register-file FIFO model: one-cycle read latency, empty flag registered.
  always @(posedge clk) begin
    if (bus.fifo_rd_op) begin
      if (fifo_q.size() > 0) bus.fifo_rd_data <= fifo_q.pop_front();
      n_read++;
    end
    bus.fifo_empty <= (fifo_q.size() == 0);
  end

  // Monitor: words read but not delivered when a reset hits are lost.
  always @(negedge clk) begin : mon
    int lose;
    if (!reset_n || !sreset_n) begin
      lose = n_read - n_deliv - n_lost;
      for (int i = 0; i < lose; i++)
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      n_lost += lose;
      model_cnt = '0;
    end else begin
      chk("rdop_while_empty", 64'(bus.fifo_empty & bus.fifo_rd_op), 64'd0);
      chk("level_le_2", 64'(bus.out_level <= 2'd2), 64'd1);
      chk("valid_vs_level", 64'(bus.out_valid), 64'(bus.out_level != 2'd0));
      chk("rd_cnt", 64'(bus.rd_cnt), 64'(model_cnt));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 64'(bus.out_data), 64'hdead_0000_0000);
        else                   chk("stream_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
        n_deliv++;
        model_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_op"},  64'(bus.fifo_rd_op), 64'd0);
    chk({tag, "_valid"},  64'(bus.out_valid),  64'd0);
    chk({tag, "_data"},   64'(bus.out_data),   64'd0);
    chk({tag, "_level"},  64'(bus.out_level),  64'd0);
    chk({tag, "_rd_cnt"}, 64'(bus.rd_cnt),     64'd0);
    chk({tag, "_err"},    64'(bus.err_sticky), 64'd0);
  endtask

  initial begin
    int k_op, k_vld, run, maxrun, ops, bad;
    bus.out_ready = 1'b0;
    bus.fifo_rd_empty_err = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rd_data = '0;
    repeat (2) tick();
    chk_reset_vals("reset");
    reset_n = 1'b1;
    tick();

    // Full-rate burst of 16 words
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(32'(i));
    k_op = -1; k_vld = -1; run = 0; maxrun = 0; ops = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.fifo_rd_op) ops++;
      if (bus.fifo_rd_op && k_op < 0) k_op = k;
      if (bus.out_valid && k_vld < 0) k_vld = k;
      run = bus.out_valid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    // rd_op sampled on one edge, data lands in the skid on the next, visible after it.
    chk("t1_latency", 64'(k_vld - k_op), 64'd2);
    chk("t1_back_to_back", 64'(maxrun), 64'd16);
    chk("t1_rd_op_count", 64'(ops), 64'd16);
    chk("t1_rd_cnt", 64'(bus.rd_cnt), 64'd16);
    chk("t1_all_delivered", 64'(exp_q.size()), 64'd0);

    // Backpressure with 4 words queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'(i));
    ops = 0; bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.fifo_rd_op) ops++;
      if (bus.out_valid && bus.out_data != 32'h0) bad++;
    end
    chk("t2_rd_op_pulses", 64'(ops), 64'd2);
    chk("t2_level", 64'(bus.out_level), 64'd2);
    chk("t2_head", 64'(bus.out_data), 64'd0);
    chk("t2_head_stable", 64'(bad), 64'd0);
    bus.out_ready = 1'b1;
    drain("t2_drain", 20);
    chk("t2_err", 64'(bus.err_sticky), 64'd0);
    chk("t2_rd_cnt", 64'(bus.rd_cnt), 64'd20);

    // Toggling ready with random data
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word($urandom);
    for (int i = 0; i < 80 && exp_q.size() > 0; i++) begin
      bus.out_ready = ~bus.out_ready;
      tick();
    end
    chk("t3_drain", 64'(exp_q.size()), 64'd0);
    chk("t3_rd_cnt", 64'(bus.rd_cnt), 64'd30);
    bus.out_ready = 1'b0;

    // Underflow error latch
    tick();
    bus.fifo_rd_empty_err = 1'b1;
    tick();
    bus.fifo_rd_empty_err = 1'b0;
    chk("t4_err_set", 64'(bus.err_sticky), 64'd1);
    repeat (3) tick();
    chk("t4_err_hold", 64'(bus.err_sticky), 64'd1);

    // Synchronous clear with one word held and one in flight
    for (int i = 0; i < 4; i++) push_word($urandom);
    for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
    chk("t5_reached_valid", 64'(bus.out_valid), 64'd1);
    chk("t5_level_before", 64'(bus.out_level), 64'd1);
    sreset_n = 1'b0;
    tick();
    sreset_n = 1'b1;
    chk("t5_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_level", 64'(bus.out_level), 64'd0);
    chk("t5_rd_cnt", 64'(bus.rd_cnt), 64'd0);
    chk("t5_err_clear", 64'(bus.err_sticky), 64'd0);
    bus.out_ready = 1'b1;
    drain("t5_drain", 20);
    chk("t5_rd_cnt_after", 64'(bus.rd_cnt), 64'd2);

    // Asynchronous reset mid-burst, away from any clock edge
    for (int i = 0; i < 12; i++) push_word($urandom);
    repeat (5) tick();
    #1 reset_n = 1'b0;
    #1 chk_reset_vals("async");
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("async_no_rd_op", 64'(bus.fifo_rd_op), 64'd0);
    end
    reset_n = 1'b1;
    drain("t6_drain", 60);
    chk("t6_fifo_empty", 64'(fifo_q.size()), 64'd0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
